// File: rtl/aes_add_round_key.sv
// AES-128 AddRoundKey stage: XORs each accepted state with the current round key
// and advances an on-the-fly key schedule by one round per accepted block.
module aes_add_round_key #(
    parameter int NR = 10
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iKeyLoad,
    input  logic [127:0] iKey,
    input  logic         iValid,
    input  logic [127:0] iData,
    output logic         oReady,
    output logic         oValid,
    output logic [127:0] oData,
    output logic [3:0]   oRound,
    output logic         oLast,
    input  logic         iReady,
    output logic         oBusy
);

    localparam logic [3:0] LP_NR = 4'(NR);

    // Forward S-box, entry x at bits [8x +: 8] (ascending range, MSB first).
    localparam logic [0:2047] LP_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] f_sbox(input logic [7:0] x);
        return LP_SBOX[{x, 3'b000} +: 8];
    endfunction

    logic         r_valid;
    logic [127:0] r_data;
    logic [3:0]   r_round;
    logic         r_last;
    logic [3:0]   r_rnd;
    logic [7:0]   r_rcon;
    logic [127:0] r_rk;
    logic [127:0] r_ck;

    logic         w_accept;
    logic [7:0]   w_sub [4];
    logic [31:0]  w_temp;
    logic [127:0] w_next_key;
    logic [7:0]   w_rcon_next;

    assign oReady   = !iKeyLoad && (!r_valid || iReady);
    assign w_accept = iValid && oReady;

    // SubWord(RotWord(w3)): temp byte gi comes from rk byte 12 + ((gi+1) mod 4).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            assign w_sub[gi] = f_sbox(r_rk[8*(12 + ((gi + 1) % 4)) +: 8]);
        end
    endgenerate

    assign w_temp      = {w_sub[3], w_sub[2], w_sub[1], w_sub[0] ^ r_rcon};
    assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1B : 8'h00);

    // Each new column word is the old one XORed with the previous new word.
    always_comb begin
        logic [31:0] v_acc;
        w_next_key = '0;
        v_acc      = w_temp;
        for (int i = 0; i < 4; i++) begin
            v_acc               = v_acc ^ r_rk[32*i +: 32];
            w_next_key[32*i +: 32] = v_acc;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_round <= '0;
            r_last  <= 1'b0;
            r_rnd   <= '0;
            r_rcon  <= 8'h01;
            r_rk    <= '0;
            r_ck    <= '0;
        end else if (iKeyLoad) begin
            r_ck    <= iKey;
            r_rk    <= iKey;
            r_rnd   <= '0;
            r_rcon  <= 8'h01;
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= iData ^ r_rk;
            r_round <= r_rnd;
            r_last  <= (r_rnd == LP_NR);
            if (r_rnd == LP_NR) begin
                r_rk   <= r_ck;
                r_rnd  <= '0;
                r_rcon <= 8'h01;
            end else begin
                r_rk   <= w_next_key;
                r_rnd  <= r_rnd + 4'd1;
                r_rcon <= w_rcon_next;
            end
        end else if (r_valid && iReady) begin
            r_valid <= 1'b0;
        end
    end

    assign oValid = r_valid;
    assign oData  = r_data;
    assign oRound = r_round;
    assign oLast  = r_last;
    assign oBusy  = (r_rnd != 4'd0);

endmodule

// File: tb/tb_aes_add_round_key.sv
// Bench for aes_add_round_key: random traffic against a word-level key-expansion
// model with a GF(2^8)-derived S-box, plus FIPS-197 known-answer and corner cases.
module tb_aes_add_round_key;

    logic         iClk = 1'b0;
    logic         iRst = 1'b1;
    logic         iKeyLoad = 1'b0;
    logic [127:0] iKey = '0;
    logic         iValid = 1'b0;
    logic [127:0] iData = '0;
    logic         oReady;
    logic         oValid;
    logic [127:0] oData;
    logic [3:0]   oRound;
    logic         oLast;
    logic         iReady = 1'b0;
    logic         oBusy;

    aes_add_round_key #(.NR(10)) dut (
        .iClk(iClk), .iRst(iRst), .iKeyLoad(iKeyLoad), .iKey(iKey),
        .iValid(iValid), .iData(iData), .oReady(oReady), .oValid(oValid),
        .oData(oData), .oRound(oRound), .oLast(oLast), .iReady(iReady),
        .oBusy(oBusy)
    );

    always #5 iClk = ~iClk;

    typedef struct packed {
        logic [127:0] d;
        logic [3:0]   r;
        logic         l;
    } exp_t;

    exp_t         sb_q[$];
    logic [127:0] m_rk [11];
    int           m_round = 0;
    int           n_cmp = 0;
    int           n_fail = 0;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] b);
        logic [7:0] inv = 8'h01;
        logic [7:0] s;
        for (int i = 0; i < 254; i++) inv = gmul(inv, b);
        if (b == 8'h00) inv = 8'h00;
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    // FIPS text order (first byte leftmost) to bus order (byte 0 at LSB).
    function automatic logic [127:0] fips(input logic [127:0] h);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = h[127-8*k -: 8];
        return r;
    endfunction

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++)
            w[i] = {key[32*i +: 8], key[32*i+8 +: 8], key[32*i+16 +: 8], key[32*i+24 +: 8]};
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            for (int c = 0; c < 4; c++)
                for (int b = 0; b < 4; b++)
                    m_rk[r][8*(4*c+b) +: 8] = w[4*r+c][31-8*b -: 8];
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- stimulus tracker: predicts accepts ----------------
    always @(negedge iClk) begin
        logic exp_ready;
        exp_ready = !iKeyLoad && (!oValid || iReady);
        chk("oReady", {127'h0, oReady}, {127'h0, exp_ready});
        if (iRst) begin
            sb_q.delete();
            m_round = 0;
        end else if (iKeyLoad) begin
            sb_q.delete();
            expand(iKey);
            m_round = 0;
        end else if (iValid && exp_ready) begin
            sb_q.push_back('{d: iData ^ m_rk[m_round], r: 4'(m_round), l: (m_round == 10)});
            m_round = (m_round == 10) ? 0 : m_round + 1;
        end
    end

    // ---------------- monitor: pops on every output transfer ----------------
    always @(negedge iClk) begin
        exp_t e;
        if (!iRst && oValid && iReady) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL out_unexpected: got data %h round %0d, expected no output", oData, oRound);
            end else begin
                e = sb_q.pop_front();
                chk("out_data", oData, e.d);
                chk("out_round", {124'h0, oRound}, {124'h0, e.r});
                chk("out_last", {127'h0, oLast}, {127'h0, e.l});
            end
        end
    end

    // ---------------- directed sequence ----------------
    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic key_load(input logic [127:0] key);
        iReady   = 1'b0;
        iValid   = 1'b1;
        iKeyLoad = 1'b1;
        iKey     = key;
        #1;
        chk("keyload_ready", {127'h0, oReady}, 128'h0);
        step();
        iKeyLoad = 1'b0;
        iValid   = 1'b0;
        chk("keyload_valid", {127'h0, oValid}, 128'h0);
        chk("keyload_busy", {127'h0, oBusy}, 128'h0);
    endtask

    logic [127:0] k_fips, k2, d_rand, hold_d;
    logic [3:0]   hold_r;

    initial begin
        k_fips = fips(128'h2b7e151628aed2a6abf7158809cf4f3c);
        repeat (2) step();
        chk("rst_valid", {127'h0, oValid}, 128'h0);
        chk("rst_data", oData, 128'h0);
        chk("rst_round", {124'h0, oRound}, 128'h0);
        chk("rst_last", {127'h0, oLast}, 128'h0);
        chk("rst_busy", {127'h0, oBusy}, 128'h0);
        iRst = 1'b0;
        step();

        // FIPS-197 Appendix B, rounds 0 and 1
        key_load(k_fips);
        iReady = 1'b1;
        iValid = 1'b1;
        iData  = fips(128'h3243f6a8885a308d313198a2e0370734);
        step();
        chk("kat_r0_valid", {127'h0, oValid}, 128'h1);
        chk("kat_r0_data", oData, fips(128'h193de3bea0f4e22b9ac68d2ae9f84808));
        chk("kat_r0_round", {124'h0, oRound}, 128'h0);
        chk("kat_r0_busy", {127'h0, oBusy}, 128'h1);
        iData = fips(128'h046681e5e0cb199a48f8d37a2806264c);
        step();
        chk("kat_r1_data", oData, fips(128'ha49c7ff2689f352b6b5bea43026a5049));
        chk("kat_r1_round", {124'h0, oRound}, 128'h1);
        iValid = 1'b0;

        // full schedule and wrap
        key_load(k_fips);
        iReady = 1'b1;
        iValid = 1'b1;
        iData  = '0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("wrap_round", {124'h0, oRound}, 128'(i % 11));
            chk("wrap_last", {127'h0, oLast}, 128'(i == 10));
            if (i == 10) begin
                chk("wrap_rk10", oData, fips(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
                chk("wrap_busy", {127'h0, oBusy}, 128'h0);
            end
            if (i == 11) chk("wrap_ck", oData, k_fips);
        end
        iValid = 1'b0;

        // randomized traffic with random backpressure
        key_load({$urandom, $urandom, $urandom, $urandom});
        for (int i = 0; i < 300; i++) begin
            iValid = ($urandom_range(0, 3) != 0);
            iReady = ($urandom_range(0, 3) != 0);
            iData  = {$urandom, $urandom, $urandom, $urandom};
            step();
        end

        // directed backpressure hold
        iReady = 1'b0;
        iValid = 1'b1;
        repeat (2) step();
        chk("bp_valid", {127'h0, oValid}, 128'h1);
        hold_d = oData;
        hold_r = oRound;
        for (int i = 0; i < 5; i++) begin
            iData = {$urandom, $urandom, $urandom, $urandom};
            step();
            chk("bp_ready", {127'h0, oReady}, 128'h0);
            chk("bp_data", oData, hold_d);
            chk("bp_round", {124'h0, oRound}, {124'h0, hold_r});
        end
        iReady = 1'b1;
        for (int i = 0; i < 20; i++) begin
            iData = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        iValid = 1'b0;

        // key reload at round 4
        key_load(k_fips);
        iReady = 1'b1;
        iValid = 1'b1;
        repeat (4) begin
            iData = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        k2 = {$urandom, $urandom, $urandom, $urandom};
        key_load(k2);
        iReady = 1'b1;
        iValid = 1'b1;
        d_rand = {$urandom, $urandom, $urandom, $urandom};
        iData  = d_rand;
        step();
        chk("reload_data", oData, d_rand ^ k2);
        chk("reload_round", {124'h0, oRound}, 128'h0);
        iValid = 1'b0;

        // asynchronous reset at round 7
        key_load(k_fips);
        iReady = 1'b1;
        iValid = 1'b1;
        repeat (7) begin
            iData = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        iValid = 1'b0;
        iReady = 1'b0;
        #2;
        iRst = 1'b1;
        #1;
        chk("arst_valid", {127'h0, oValid}, 128'h0);
        chk("arst_data", oData, 128'h0);
        chk("arst_round", {124'h0, oRound}, 128'h0);
        chk("arst_last", {127'h0, oLast}, 128'h0);
        chk("arst_busy", {127'h0, oBusy}, 128'h0);
        repeat (2) step();
        iRst   = 1'b0;
        iReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("arst_idle", {127'h0, oValid}, 128'h0);
        end
        key_load(k_fips);
        iReady = 1'b1;
        iValid = 1'b1;
        d_rand = {$urandom, $urandom, $urandom, $urandom};
        iData  = d_rand;
        step();
        iValid = 1'b0;
        chk("arst_after_data", oData, d_rand ^ k_fips);

        repeat (3) step();
        chk("drain_empty", 128'(sb_q.size()), 128'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
